counter_nbit: RTL
=================

Name: counter_nbit

Overview:
Parametrised synchronous up/down counter, the generalised successor to the fixed 8-bit enable counter used in the quicklogic test designs.
- Adds configurable width and modulus, direction control, and parallel load.
- Adds wrap or saturate mode, terminal-count pulse and sticky wrap flag.
- Serves as a reusable counting primitive in the pp3 test designs and as a sequential-logic regression target for packing and placement.

Parameters:
- WIDTH, 8, counter width in bits (2..32).
- MAX_COUNT, 2**WIDTH-1, highest legal count value; the modulus is MAX_COUNT+1.
- RESET_VALUE, 2**WIDTH-1, count value after reset; clamped to MAX_COUNT.
- SATURATE, 0, 0 = wrap at the limits, 1 = hold at the limits.
- PRESCALE, 4, enable divide ratio (>=2); used only when COUNTER_NBIT_PRESCALE_EN is defined.

Ports:
- clk  input  1  single rising-edge clock.
- rst  input  1  synchronous active-high reset.
- enable  input  1  count qualifier; sampled each clk.
- dir  input  1  0 = up, 1 = down.
- load  input  1  parallel load strobe.
- load_value  input  WIDTH  value taken on load.
- clr_flag  input  1  clears wrap_flag.
- count  output  WIDTH  registered count.
- tc  output  1  registered terminal-count pulse.
- wrap_flag  output  1  sticky limit-event flag.
- at_limit  output  1  combinational: (dir==0 && count==MAX_COUNT) || (dir==1 && count==0).

Behaviour:
- Interface: one clock, clk; reset is synchronous and active-high, rst.
- Reset: on a clk edge with rst=1, count<=min(RESET_VALUE,MAX_COUNT), tc<=0, wrap_flag<=0 and the prescaler <=0. rst overrides every other input, including load.
- Priority per edge: rst > load > enable step.
- Load: count<=min(load_value,MAX_COUNT).
  - tc<=0.
  - The prescaler is cleared.
  - wrap_flag is unchanged.
- Step: when enable=1 and load=0, count moves one step on the same edge (1-cycle latency; visible the next cycle).
  - Up: count+1.
  - Down: count-1.
- Limit event: a step attempted while at_limit=1.
  - Wrap mode (SATURATE=0): up at MAX_COUNT goes to 0; down at 0 goes to MAX_COUNT.
  - Saturate mode (SATURATE=1): count holds.
  - Either mode: tc<=1 for that cycle only, and wrap_flag<=1.
- tc: 0 in every cycle without a limit event. In saturate mode, tc pulses again on every further blocked step.
- wrap_flag: cleared by clr_flag=1. If a limit event occurs on the same edge as clr_flag, set wins.
- dir may change on any cycle; the step uses the value of dir sampled on that edge.
- Arithmetic is modulo MAX_COUNT+1, never 2**WIDTH. Intermediate sums use WIDTH+1 bits, so MAX_COUNT=2**WIDTH-1 cannot overflow.
- enable=0 and load=0: count holds and tc<=0.

Optional Feature:
COUNTER_NBIT_PRESCALE_EN
- Defined: the enable=1 cycles feed a modulo-PRESCALE prescaler.
  - The counter steps only on the PRESCALE-th qualified enable; the limit-event rules apply to that step only.
  - The prescaler is cleared by rst and by load. It holds while enable=0.
- Undefined: no prescaler logic is generated; every enable=1 cycle is a step. The PRESCALE parameter is ignored.

Decomposition:
- Package counter_nbit_pkg:
  - typedef enum of the dir encoding (CNT_DIR_UP=1'b0, CNT_DIR_DOWN=1'b1).
  - Constants CNT_MODE_WRAP=0 and CNT_MODE_SAT=1 for SATURATE.
  - Function clamp_to_max(value, max).
- Sub-module counter_nbit_prescaler: a modulo-PRESCALE divider with inputs clk, rst, clr and en_in, and output en_out. It is instantiated only under COUNTER_NBIT_PRESCALE_EN.
- All count, limit and flag logic stays in counter_nbit.

Test Plan:
1. Defaults; rst=1 for 2 cycles while load=1 and load_value=8'h12 -> count=8'hFF, tc=0, wrap_flag=0, at_limit=1 (dir=0).
2. Defaults, count=8'hFF, enable=1, dir=0 for 1 cycle -> count=8'h00, tc=1 for exactly 1 cycle, wrap_flag=1. clr_flag=1 next cycle -> wrap_flag=0.
3. MAX_COUNT=9; load with load_value=0, then dir=1, enable=1 for 3 cycles -> count 9, 8, 7; tc=1 only on the 0->9 edge.
4. SATURATE=1; count=8'hFE, dir=0, enable=1 for 3 cycles -> count FF, FF, FF; tc=0, 1, 1. dir=1 for 1 cycle -> count=FE, tc=0.
5. MAX_COUNT=99; load=1 with load_value=200 and enable=1 on the same edge -> count=99, no step. rst asserted mid-count at count=50 -> count=99 the next cycle.
6. COUNTER_NBIT_PRESCALE_EN, PRESCALE=4; load with load_value=0, then 8 consecutive enable=1 cycles -> count=2. With the macro undefined, the same stimulus -> count=8.

Source files
------------

// File: rtl/counter_nbit_pkg.sv
// -----------------------------------------------------------------------------
// counter_nbit_pkg
// Shared definitions for the counter_nbit counting primitive:
//   cnt_dir_e      - direction encoding for the dir input
//   CNT_MODE_WRAP  - SATURATE value selecting wrap-around at the limits
//   CNT_MODE_SAT   - SATURATE value selecting hold at the limits
//   clamp_to_max() - limits a value to a maximum (used for reset and load)
// -----------------------------------------------------------------------------
package counter_nbit_pkg;

   typedef enum logic {
      CNT_DIR_UP   = 1'b0,
      CNT_DIR_DOWN = 1'b1
   } cnt_dir_e;

   localparam int CNT_MODE_WRAP = 0;
   localparam int CNT_MODE_SAT  = 1;

   // 33 bits so that any WIDTH up to 32 fits without sign or overflow issues.
   function automatic logic [32:0] clamp_to_max(input logic [32:0] value,
                                                input logic [32:0] max);
      return (value > max) ? max : value;
   endfunction

endpackage

// File: rtl/counter_nbit_prescaler.sv
// -----------------------------------------------------------------------------
// counter_nbit_prescaler
// Modulo-PRESCALE enable divider: en_out is asserted on every PRESCALE-th
// cycle in which en_in is high. The phase holds while en_in is low.
// Ports:
//   clk    in  rising-edge clock
//   rst    in  synchronous active-high reset (phase <= 0)
//   clr    in  synchronous phase clear (phase <= 0)
//   en_in  in  qualified enable to be divided
//   en_out out combinational: en_in on the last phase of the divider
// -----------------------------------------------------------------------------
module counter_nbit_prescaler #(
   parameter int PRESCALE = 4
) (
   input  logic clk,
   input  logic rst,
   input  logic clr,
   input  logic en_in,
   output logic en_out
);

   localparam int            L_W    = (PRESCALE > 2) ? $clog2(PRESCALE) : 1;
   localparam logic [L_W-1:0] L_LAST = L_W'(PRESCALE - 1);

   logic [L_W-1:0] r_div;

   assign en_out = en_in && (r_div == L_LAST);

   always_ff @(posedge clk) begin
      if (rst || clr) begin
         r_div <= '0;
      end else if (en_in) begin
         r_div <= (r_div == L_LAST) ? '0 : r_div + 1'b1;
      end
   end

endmodule

// File: rtl/counter_nbit.sv
// -----------------------------------------------------------------------------
// counter_nbit
// Parametrised synchronous up/down counter with modulus MAX_COUNT+1, parallel
// load, wrap or saturate at the limits, terminal-count pulse and sticky flag.
// Optional enable prescaler: define COUNTER_NBIT_PRESCALE_EN to make the
// counter step only on every PRESCALE-th enable=1 cycle.
// Ports:
//   clk        in  rising-edge clock
//   rst        in  synchronous active-high reset (overrides everything)
//   enable     in  count qualifier
//   dir        in  0 = up, 1 = down
//   load       in  parallel load strobe (beats enable)
//   load_value in  [WIDTH] value taken on load, clamped to MAX_COUNT
//   clr_flag   in  clears wrap_flag (a simultaneous limit event wins)
//   count      out [WIDTH] registered count
//   tc         out registered one-cycle pulse on each limit event
//   wrap_flag  out sticky limit-event flag
//   at_limit   out combinational: next step in direction dir is a limit event
// -----------------------------------------------------------------------------
module counter_nbit
   import counter_nbit_pkg::*;
#(
   parameter int               WIDTH       = 8,
   parameter logic [WIDTH-1:0] MAX_COUNT   = {WIDTH{1'b1}},
   parameter logic [WIDTH-1:0] RESET_VALUE = {WIDTH{1'b1}},
   parameter int               SATURATE    = CNT_MODE_WRAP,
   parameter int               PRESCALE    = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             enable,
   input  logic             dir,
   input  logic             load,
   input  logic [WIDTH-1:0] load_value,
   input  logic             clr_flag,
   output logic [WIDTH-1:0] count,
   output logic             tc,
   output logic             wrap_flag,
   output logic             at_limit
);

   localparam logic [32:0]      L_RESET_FULL = clamp_to_max(33'(RESET_VALUE), 33'(MAX_COUNT));
   localparam logic [WIDTH-1:0] L_RESET      = L_RESET_FULL[WIDTH-1:0];

   logic [WIDTH-1:0] r_count;
   logic             r_tc;
   logic             r_wrap_flag;

   cnt_dir_e         w_dir;
   logic             w_at_limit;
   logic             w_step;
   logic [32:0]      w_load_full;
   logic [WIDTH-1:0] w_load_clamped;
   logic [WIDTH:0]   w_up_sum;
   logic [WIDTH-1:0] w_dn_diff;
   logic [WIDTH-1:0] w_count_next;
   logic             w_unused;

   assign w_dir = cnt_dir_e'(dir);

   assign w_at_limit = ((w_dir == CNT_DIR_UP)   && (r_count == MAX_COUNT)) ||
                       ((w_dir == CNT_DIR_DOWN) && (r_count == '0));

   assign w_load_full    = clamp_to_max(33'(load_value), 33'(MAX_COUNT));
   assign w_load_clamped = w_load_full[WIDTH-1:0];

   // Step qualifier. load has priority, so a loading cycle never counts as a
   // qualified enable for either the counter or the prescaler.
`ifdef COUNTER_NBIT_PRESCALE_EN
   counter_nbit_prescaler #(
      .PRESCALE (PRESCALE)
   ) u_prescaler (
      .clk    (clk),
      .rst    (rst),
      .clr    (load),
      .en_in  (enable && !load),
      .en_out (w_step)
   );
`else
   assign w_step = enable && !load;
`endif

   // The limit check runs before the increment is used, so the sum never has
   // to wrap at 2**WIDTH; the extra sum bit only guards MAX_COUNT=2**WIDTH-1.
   assign w_up_sum  = {1'b0, r_count} + 1'b1;
   assign w_dn_diff = r_count - 1'b1;

   always_comb begin
      w_count_next = r_count;
      if (w_at_limit) begin
         if (SATURATE == CNT_MODE_SAT) begin
            w_count_next = r_count;
         end else if (w_dir == CNT_DIR_UP) begin
            w_count_next = '0;
         end else begin
            w_count_next = MAX_COUNT;
         end
      end else if (w_dir == CNT_DIR_UP) begin
         w_count_next = w_up_sum[WIDTH-1:0];
      end else begin
         w_count_next = w_dn_diff;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_count     <= L_RESET;
         r_tc        <= 1'b0;
         r_wrap_flag <= 1'b0;
      end else if (load) begin
         r_count <= w_load_clamped;
         r_tc    <= 1'b0;
         if (clr_flag) begin
            r_wrap_flag <= 1'b0;
         end
      end else begin
         if (w_step) begin
            r_count <= w_count_next;
            r_tc    <= w_at_limit;
         end else begin
            r_tc    <= 1'b0;
         end
         // Set beats clear when both happen on the same edge.
         if (w_step && w_at_limit) begin
            r_wrap_flag <= 1'b1;
         end else if (clr_flag) begin
            r_wrap_flag <= 1'b0;
         end
      end
   end

   // Bits that are structurally never needed (carry-out, clamp upper bits)
   // and the prescale ratio when the prescaler is not built.
   assign w_unused = w_up_sum[WIDTH] ^ (^w_load_full[32:WIDTH]) ^ (PRESCALE < 2);

   assign count     = r_count;
   assign tc        = r_tc;
   assign wrap_flag = r_wrap_flag;
   assign at_limit  = w_at_limit;

endmodule
